ibex_trace_buffer: RTL

Parametrised on-chip retirement trace buffer for the dual-lockstep Ibex. It sits beside `ibex_top` and consumes the RVFI retirement stream from 1 or 2 cores. It stores compact retirement records in a circular buffer under a selectable capture mode, and exposes them through a valid/ready pop port. It replaces simulation-only printing with a synthesizable, debugger-readable trace. With two channels it also checks the lockstep cores retire identically and freezes the trace on divergence.

---
 rtl/ibex_trace_pkg.sv | 31 +++
 rtl/ibex_trace_lockstep_cmp.sv | 40 ++++
 rtl/ibex_trace_buffer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ibex_trace_pkg.sv
// ibex_trace_pkg
// Shared types for the Ibex retirement trace buffer:
//   trace_rec_t   - one compact retirement record
//   trace_mode_e  - capture mode selected when the buffer is armed
//   trace_state_e - capture controller state
package ibex_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic        trap;
    logic        intr;
  } trace_rec_t;

  // Encoding 3 is reserved and behaves like TraceWrap.
  typedef enum logic [1:0] {
    TraceWrap    = 2'd0,
    TraceFill    = 2'd1,
    TraceTrigger = 2'd2
  } trace_mode_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StPost    = 2'd2,
    StFrozen  = 2'd3
  } trace_state_e;

endpackage

// File: rtl/ibex_trace_lockstep_cmp.sv
// ibex_trace_lockstep_cmp
// Purely combinational comparison of two lockstep RVFI retirement channels.
// Ports:
//   valid_i               - per-channel retirement strobe
//   pc_i/insn_i/wdata_i   - per-channel retired PC, instruction, rd write data
//   rd_addr_i             - per-channel destination register
//   trap_i/intr_i         - per-channel trap / interrupt-entry flags
//   mismatch_o            - channels disagree this cycle
module ibex_trace_lockstep_cmp
  import ibex_trace_pkg::*;
(
  input  logic [1:0]       valid_i,
  input  logic [1:0][31:0] pc_i,
  input  logic [1:0][31:0] insn_i,
  input  logic [1:0][31:0] wdata_i,
  input  logic [1:0][4:0]  rd_addr_i,
  input  logic [1:0]       trap_i,
  input  logic [1:0]       intr_i,
  output logic             mismatch_o
);

  trace_rec_t rec [2];

  // Pack each channel into the record layout so the whole record compares at once.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      rec[c].pc       = pc_i[c];
      rec[c].insn     = insn_i[c];
      rec[c].rd_wdata = wdata_i[c];
      rec[c].rd_addr  = rd_addr_i[c];
      rec[c].trap     = trap_i[c];
      rec[c].intr     = intr_i[c];
    end
  end

  // Record contents only matter when both cores actually retired.
  assign mismatch_o = (valid_i[0] != valid_i[1]) ||
                      (valid_i[0] && valid_i[1] && (rec[0] != rec[1]));

endmodule

// File: rtl/ibex_trace_buffer.sv
// ibex_trace_buffer
// Circular retirement trace buffer fed by the RVFI stream of 1 or 2 lockstep cores.
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   rvfi_*_i               - per-channel retirement stream (channel 0 recorded)
//   mode_i, arm_i, clear_i - capture mode (sampled on arm), arm pulse, clear pulse
//   rd_valid_o/rd_ready_i  - pop handshake for the oldest record, rd_data_o
//   count_o                - number of stored records
//   capturing_o, frozen_o, overflow_o, mismatch_o - status flags
module ibex_trace_buffer
  import ibex_trace_pkg::*;
#(
  parameter int NumChannels   = 1,
  parameter int Depth         = 16,
  parameter int PostTrigCount = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumChannels-1:0]           rvfi_valid_i,
  input  logic [NumChannels-1:0][31:0]     rvfi_pc_rdata_i,
  input  logic [NumChannels-1:0][31:0]     rvfi_insn_i,
  input  logic [NumChannels-1:0][31:0]     rvfi_rd_wdata_i,
  input  logic [NumChannels-1:0][4:0]      rvfi_rd_addr_i,
  input  logic [NumChannels-1:0]           rvfi_trap_i,
  input  logic [NumChannels-1:0]           rvfi_intr_i,
  input  logic [1:0]                       mode_i,
  input  logic                             arm_i,
  input  logic                             clear_i,
  output logic                             rd_valid_o,
  input  logic                             rd_ready_i,
  output trace_rec_t                       rd_data_o,
  output logic [$clog2(Depth+1)-1:0]       count_o,
  output logic                             capturing_o,
  output logic                             frozen_o,
  output logic                             overflow_o,
  output logic                             mismatch_o
);

  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);
  localparam logic [CW-1:0] CountFull = CW'(Depth);
  localparam logic [PW-1:0] PostLoad  = PW'(PostTrigCount);

  trace_state_e  state_q, state_d;
  logic [1:0]    mode_q;
  logic [PW-1:0] wptr_q, rptr_q, post_q, post_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, mismatch_q;
  trace_rec_t    mem_q [Depth];

  trace_rec_t rec0;
  logic       active, push, pop, full, rptr_adv, lockstep_mismatch, mismatch_event;

  assign rec0.pc       = rvfi_pc_rdata_i[0];
  assign rec0.insn     = rvfi_insn_i[0];
  assign rec0.rd_wdata = rvfi_rd_wdata_i[0];
  assign rec0.rd_addr  = rvfi_rd_addr_i[0];
  assign rec0.trap     = rvfi_trap_i[0];
  assign rec0.intr     = rvfi_intr_i[0];

  generate
    if (NumChannels == 2) begin : g_lockstep
      ibex_trace_lockstep_cmp u_cmp (
        .valid_i    (rvfi_valid_i),
        .pc_i       (rvfi_pc_rdata_i),
        .insn_i     (rvfi_insn_i),
        .wdata_i    (rvfi_rd_wdata_i),
        .rd_addr_i  (rvfi_rd_addr_i),
        .trap_i     (rvfi_trap_i),
        .intr_i     (rvfi_intr_i),
        .mismatch_o (lockstep_mismatch)
      );
    end else begin : g_single
      assign lockstep_mismatch = 1'b0;
    end
  endgenerate

  // Arming and clearing take the whole cycle, so retirements then are dropped.
  assign active         = (state_q == StCapture) || (state_q == StPost);
  assign push           = active && rvfi_valid_i[0] && !arm_i && !clear_i;
  assign mismatch_event = active && lockstep_mismatch && !arm_i && !clear_i;
  assign full           = (count_q == CountFull);
  assign pop            = (count_q != '0) && rd_ready_i;
  assign rptr_adv       = pop || (push && full);

  // Occupancy: an overwrite of a full buffer or a push+pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop && !full) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Capture controller next state: arm restarts, mismatch freezes, then mode rules.
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    if (arm_i) begin
      state_d = StCapture;
    end else if (mismatch_event) begin
      state_d = StFrozen;
    end else if (push) begin
      if (mode_q == TraceFill) begin
        if (count_d == CountFull) begin
          state_d = StFrozen;
        end
      end else if (mode_q == TraceTrigger) begin
        if (state_q == StPost) begin
          post_d = post_q - PW'(1);
          if (post_q == PW'(1)) begin
            state_d = StFrozen;
          end
        end else if (rec0.trap) begin
          post_d  = PostLoad;
          state_d = (PostTrigCount == 0) ? StFrozen : StPost;
        end
      end
    end
  end

  // Control registers; clear outranks arm and wipes occupancy and flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      mode_q     <= 2'd0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      post_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else if (clear_i) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      post_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (rptr_adv) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (arm_i) begin
        mode_q     <= mode_i;
        overflow_q <= 1'b0;
        mismatch_q <= 1'b0;
      end else begin
        if (push && full && !pop) begin
          overflow_q <= 1'b1;
        end
        if (mismatch_event) begin
          mismatch_q <= 1'b1;
        end
      end
    end
  end

  // Record storage has no reset; entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= rec0;
    end
  end

  assign rd_valid_o  = (count_q != '0);
  assign rd_data_o   = mem_q[rptr_q];
  assign count_o     = count_q;
  assign capturing_o = active;
  assign frozen_o    = (state_q == StFrozen);
  assign overflow_o  = overflow_q;
  assign mismatch_o  = mismatch_q;

endmodule
